// File: rtl/spi_flash_reader.sv
// SPI NOR word fetcher: issues READ (0x03) with a word-aligned 24-bit address, clocks in four bytes
// in SPI mode 0, and returns them little-endian with a one-cycle completion pulse.
module spi_flash_reader #(
   parameter int CLK_DIV        = 2,
   parameter int CS_HIGH_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic        mem_rstrb,
   output logic        mem_done,
   output logic        spi_sck_o,
   output logic        spi_cs_no,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i
);

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV);
   localparam logic [7:0] CS_LOAD  = 8'(CS_HIGH_CYCLES);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, CS_HIGH} state_t;

   state_t      state;
   logic [7:0]  div_cnt;
   logic [6:0]  bit_cnt;
   logic [7:0]  cs_cnt;
   logic [31:0] tx_sr;
   logic [31:0] rx_sr;
   logic [31:0] tx_word;
   logic        unused_addr;

   assign tx_word     = {8'h03, mem_addr[23:2], 2'b00};
   assign unused_addr = ^{mem_addr[31:24], mem_addr[1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         cs_cnt     <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         mem_rdata  <= '0;
         mem_done   <= 1'b0;
         spi_sck_o  <= 1'b0;
         spi_cs_no  <= 1'b1;
         spi_mosi_o <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_rstrb && !mem_done) begin
                  tx_sr      <= tx_word;
                  spi_mosi_o <= tx_word[31];
                  spi_cs_no  <= 1'b0;
                  spi_sck_o  <= 1'b0;
                  div_cnt    <= DIV_LOAD;
                  bit_cnt    <= '0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == 8'd1) begin
                  div_cnt <= DIV_LOAD;
                  if (!spi_sck_o) begin
                     spi_sck_o <= 1'b1;
                     rx_sr     <= {rx_sr[30:0], spi_miso_i};
                  end else begin
                     spi_sck_o <= 1'b0;
                     bit_cnt   <= bit_cnt + 7'd1;
                     // Zero fill of tx_sr makes MOSI fall to 0 by itself once the 32 TX bits are out.
                     tx_sr      <= {tx_sr[30:0], 1'b0};
                     spi_mosi_o <= tx_sr[30];
                     if (bit_cnt == 7'd63) begin
                        state <= DONE;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            DONE: begin
               // First received byte sits in rx_sr[31:24]; it belongs in the low byte.
               mem_rdata  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
               mem_done   <= 1'b1;
               spi_cs_no  <= 1'b1;
               spi_sck_o  <= 1'b0;
               spi_mosi_o <= 1'b0;
               cs_cnt     <= CS_LOAD;
               state      <= CS_HIGH;
            end
            CS_HIGH: begin
               if (cs_cnt <= 8'd1) begin
                  state <= IDLE;
               end else begin
                  cs_cnt <= cs_cnt - 8'd1;
               end
            end
            default: begin
               state      <= IDLE;
               spi_cs_no  <= 1'b1;
               spi_sck_o  <= 1'b0;
               spi_mosi_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
